// File: rtl/data_ram_ctrl_pkg.sv
// Shared encodings for the MEM-stage data RAM controller: request direction,
// big-endian lane mapping and controller FSM states.
package data_ram_ctrl_pkg;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    // Bits_Sel bit that carries the byte at each big-endian byte offset.
    localparam int LANE_OF_OFFSET0 = 3;
    localparam int LANE_OF_OFFSET1 = 2;
    localparam int LANE_OF_OFFSET2 = 1;
    localparam int LANE_OF_OFFSET3 = 0;

    typedef enum logic [1:0] {
        DRC_IDLE    = 2'b00,
        DRC_RD_WAIT = 2'b01,
        DRC_RD_DONE = 2'b10
    } drc_state_t;

    function automatic int lane_of_offset(input int offset);
        return 3 - offset;
    endfunction

endpackage

// File: rtl/data_ram_array.sv
// Word-organised storage with four byte-lane write enables, clocked write
// and asynchronous read. Contents are not reset.
module data_ram_array #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic [3:0]            lane_we,
    input  logic [ADDR_WIDTH-1:0] wr_idx,
    input  logic [31:0]           wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_idx,
    output logic [31:0]           rd_data
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) begin
                mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/data_ram_ctrl.sv
// Responder for the MEM-stage data bus: byte-lane writes with no stall and
// multi-cycle reads that hold the pipeline via stall_req until data is valid.
module data_ram_ctrl
    import data_ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int READ_LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_en,
    input  logic        wr_en,
    input  logic [3:0]  Bits_Sel,
    input  logic [31:0] ram_addr,
    input  logic [31:0] data_to_ram,
    output logic [31:0] data_from_ram,
    output logic        stall_req,
    output logic        addr_err
);

    localparam logic [2:0] CNT_START = 3'(READ_LAT - 1);

    drc_state_t            state, state_next;
    logic [2:0]            cnt;
    logic [31:0]           data_reg;
    logic [ADDR_WIDTH-1:0] req_idx;
    logic                  req_err;

    logic [ADDR_WIDTH-1:0] idx;
    logic                  err_raw;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [31:0]           rd_data;
    logic                  rd_err;
    logic [3:0]            lane_we;
    logic                  load_req;
    logic                  dec_cnt;
    logic                  capture;
    logic                  addr_lsb_unused;

    assign idx             = ram_addr[ADDR_WIDTH+1:2];
    assign err_raw         = ram_en & (ram_addr[31:ADDR_WIDTH+2] != '0);
    assign addr_err        = rst ? 1'b0 : err_raw;
    assign addr_lsb_unused = ^ram_addr[1:0];

    assign lane_we = (state == DRC_IDLE && ram_en && wr_en == WRITE && !err_raw && !rst)
                     ? Bits_Sel : 4'b0000;

    // The latched request index is used once waiting; in IDLE the live index
    // serves the single-cycle-latency capture.
    assign rd_idx = (state == DRC_RD_WAIT) ? req_idx : idx;
    assign rd_err = (state == DRC_RD_WAIT) ? req_err : err_raw;

    data_ram_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .lane_we (lane_we),
        .wr_idx  (idx),
        .wr_data (data_to_ram),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DRC_IDLE;
            cnt      <= 3'd0;
            data_reg <= 32'd0;
            req_idx  <= '0;
            req_err  <= 1'b0;
        end else begin
            state <= state_next;
            if (load_req) begin
                req_idx <= idx;
                req_err <= err_raw;
                cnt     <= CNT_START;
            end else if (dec_cnt) begin
                cnt <= cnt - 3'd1;
            end
            if (capture) begin
                data_reg <= rd_err ? 32'd0 : rd_data;
            end
        end
    end

    // Dropping ram_en while waiting or completing is a flush: release the stall
    // and discard the read.
    always_comb begin
        state_next    = state;
        stall_req     = 1'b0;
        data_from_ram = 32'd0;
        load_req      = 1'b0;
        dec_cnt       = 1'b0;
        capture       = 1'b0;
        case (state)
            DRC_IDLE: begin
                if (ram_en && wr_en == READ) begin
                    stall_req = 1'b1;
                    load_req  = 1'b1;
                    if (READ_LAT == 1) begin
                        capture    = 1'b1;
                        state_next = DRC_RD_DONE;
                    end else begin
                        state_next = DRC_RD_WAIT;
                    end
                end
            end
            DRC_RD_WAIT: begin
                if (!ram_en) begin
                    state_next = DRC_IDLE;
                end else begin
                    stall_req = 1'b1;
                    dec_cnt   = 1'b1;
                    if (cnt == 3'd1) begin
                        capture    = 1'b1;
                        state_next = DRC_RD_DONE;
                    end
                end
            end
            DRC_RD_DONE: begin
                state_next = DRC_IDLE;
                if (ram_en) begin
                    data_from_ram = data_reg;
                end
            end
            default: begin
                state_next = DRC_IDLE;
            end
        endcase
        if (rst) begin
            stall_req     = 1'b0;
            data_from_ram = 32'd0;
        end
    end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Self-checking bench for data_ram_ctrl: directed steps plus randomized traffic
// compared against a word-array model, and a READ_LAT=1 instance.
module tb_data_ram_ctrl;
    import data_ram_ctrl_pkg::*;

    localparam int AW  = 10;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_en, wr_en;
    logic [3:0]  bits_sel;
    logic [31:0] ram_addr, data_to_ram;
    logic [31:0] data_from_ram;
    logic        stall_req, addr_err;

    logic        r1_en, r1_we;
    logic [3:0]  r1_sel;
    logic [31:0] r1_addr, r1_wdata;
    logic [31:0] r1_rdata;
    logic        r1_stall, r1_err;

    int total  = 0;
    int passed = 0;
    logic [31:0] model [int];

    always #5 clk = ~clk;

    data_ram_ctrl #(.ADDR_WIDTH(AW), .READ_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .ram_en(ram_en), .wr_en(wr_en), .Bits_Sel(bits_sel),
        .ram_addr(ram_addr), .data_to_ram(data_to_ram), .data_from_ram(data_from_ram),
        .stall_req(stall_req), .addr_err(addr_err)
    );

    data_ram_ctrl #(.ADDR_WIDTH(AW), .READ_LAT(1)) dut_lat1 (
        .clk(clk), .rst(rst), .ram_en(r1_en), .wr_en(r1_we), .Bits_Sel(r1_sel),
        .ram_addr(r1_addr), .data_to_ram(r1_wdata), .data_from_ram(r1_rdata),
        .stall_req(r1_stall), .addr_err(r1_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic en, input logic we, input logic [3:0] sel,
                                 input logic [31:0] addr, input logic [31:0] data);
        ram_en      = en;
        wr_en       = we;
        bits_sel    = sel;
        ram_addr    = addr;
        data_to_ram = data;
    endtask

    function automatic logic in_range(input logic [31:0] addr);
        return addr < (32'd4 << AW);
    endfunction

    // Byte at big-endian offset k lives in bits [31-8k -: 8] and is enabled by its lane bit.
    task automatic modelWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
        int w;
        logic [31:0] word;
        if (!in_range(addr)) return;
        w = int'(addr / 4);
        word = model.exists(w) ? model[w] : 32'hxxxx_xxxx;
        for (int k = 0; k < 4; k++) begin
            if (sel[lane_of_offset(k)]) word[31-8*k -: 8] = data[31-8*k -: 8];
        end
        model[w] = word;
    endtask

    task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
        applyStimulus(1'b1, WRITE, sel, addr, data);
        #1;
        checkOutput("wr_stall", {31'd0, stall_req}, 32'd0);
        checkOutput("wr_data", data_from_ram, 32'd0);
        checkOutput("wr_err", {31'd0, addr_err}, {31'd0, !in_range(addr)});
        @(posedge clk);
        modelWrite(addr, data, sel);
        #1;
    endtask

    task automatic doRead(input logic [31:0] addr, input string tag);
        logic [31:0] exp;
        exp = in_range(addr) ? model[int'(addr / 4)] : 32'd0;
        applyStimulus(1'b1, READ, 4'($urandom_range(0, 15)), addr, $urandom);
        #1;
        for (int c = 0; c < LAT; c++) begin
            checkOutput({tag, "_stall"}, {31'd0, stall_req}, 32'd1);
            checkOutput({tag, "_wait_data"}, data_from_ram, 32'd0);
            checkOutput({tag, "_err"}, {31'd0, addr_err}, {31'd0, !in_range(addr)});
            @(posedge clk);
            #1;
        end
        checkOutput({tag, "_done_stall"}, {31'd0, stall_req}, 32'd0);
        checkOutput({tag, "_data"}, data_from_ram, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic doIdle();
        applyStimulus(1'b0, READ, 4'h0, 32'h0, 32'h0);
        #1;
        checkOutput("idle_stall", {31'd0, stall_req}, 32'd0);
        checkOutput("idle_data", data_from_ram, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] addr;
        rst = 1'b1;
        r1_en = 1'b0; r1_we = READ; r1_sel = 4'h0; r1_addr = 32'h0; r1_wdata = 32'h0;
        applyStimulus(1'b1, READ, 4'hF, 32'h0000_1000, 32'h0);
        #2;
        checkOutput("rst_stall", {31'd0, stall_req}, 32'd0);
        checkOutput("rst_data", data_from_ram, 32'd0);
        checkOutput("rst_err", {31'd0, addr_err}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        doIdle();

        doWrite(32'h10, 32'h1234_5678, 4'b1111);
        doRead(32'h10, "lw_full");
        doWrite(32'h11, 32'hAAAA_AAAA, 4'b0100);
        doRead(32'h10, "lw_sb");
        doWrite(32'h12, 32'hBEEF_BEEF, 4'b0011);
        doRead(32'h10, "lw_sh");
        checkOutput("model_sh", model[4], 32'h12AA_BEEF);

        doWrite(32'h0, 32'h0102_0304, 4'b1111);
        doWrite(32'h0000_1000, 32'hFFFF_FFFF, 4'b1111);
        doRead(32'h0, "lw_word0");
        doRead(32'h0000_1000, "lw_oor");

        // Flush during the first wait cycle.
        applyStimulus(1'b1, READ, 4'hF, 32'h10, 32'h0);
        #1;
        checkOutput("abort_req_stall", {31'd0, stall_req}, 32'd1);
        @(posedge clk);
        #1;
        ram_en = 1'b0;
        #1;
        checkOutput("abort_stall", {31'd0, stall_req}, 32'd0);
        checkOutput("abort_data", data_from_ram, 32'd0);
        @(posedge clk);
        #1;
        doIdle();
        doRead(32'h10, "lw_after_abort");

        // Reset while waiting.
        applyStimulus(1'b1, READ, 4'hF, 32'h10, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rstmid_stall", {31'd0, stall_req}, 32'd0);
        checkOutput("rstmid_data", data_from_ram, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        doIdle();
        doRead(32'h10, "lw_after_rst");

        for (int k = 0; k < 8; k++) doWrite(32'h100 + 32'(4*k), $urandom, 4'b1111);
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0)
                addr = $urandom | 32'h0000_1000;
            else
                addr = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0, 1:    doWrite(addr, $urandom, 4'($urandom_range(0, 15)));
                2, 3:    doRead(addr, "rand_lw");
                default: doIdle();
            endcase
        end
        doRead(32'h0, "final_word0");
        doRead(32'h10, "final_word4");

        // Write immediately followed by a read on the single-cycle-latency instance.
        applyStimulus(1'b0, READ, 4'h0, 32'h0, 32'h0);
        r1_en = 1'b1; r1_we = WRITE; r1_sel = 4'hF; r1_addr = 32'h20; r1_wdata = 32'hCAFE_F00D;
        #1;
        checkOutput("lat1_wr_stall", {31'd0, r1_stall}, 32'd0);
        @(posedge clk);
        #1;
        r1_we = READ; r1_sel = 4'h0; r1_wdata = 32'h0;
        #1;
        checkOutput("lat1_stall", {31'd0, r1_stall}, 32'd1);
        checkOutput("lat1_wait_data", r1_rdata, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("lat1_done_stall", {31'd0, r1_stall}, 32'd0);
        checkOutput("lat1_data", r1_rdata, 32'hCAFE_F00D);
        r1_en = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("lat1_idle_stall", {31'd0, r1_stall}, 32'd0);
        checkOutput("lat1_idle_data", r1_rdata, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
